muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It replaces single-cycle MULT/DIV inside the ALU with a WIDTH-cycle shift-add multiplier and a restoring divider, supporting signed and unsigned modes. A start/busy/done handshake lets the control FSM stall on MFHI/MFLO while an operation is in flight. MTHI/MTLO write ports are included.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide: shift-add multiplier, restoring divider, signed/unsigned.
// Latency: result and done pulse WIDTH+1 edges after the start edge; one op per WIDTH+3 cycles.
// Backpressure: none; start is ignored while busy, and MTHI/MTLO writes only land in idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_a;
    logic               neg_res;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               sgn_in;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shift_rem;
    logic               take;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   a_raw;

    always_comb begin
        sgn_in    = ~op[0];
        a_in      = (sgn_in && src_a[WIDTH-1]) ? -src_a : src_a;
        b_in      = (sgn_in && src_b[WIDTH-1]) ? -src_b : src_b;
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        // acc[WIDTH-1:0] doubles as the dividend/quotient shift register when dividing
        shift_rem = {rem, acc[WIDTH-1]};
        take      = (shift_rem >= {1'b0, b_mag});
        mul_res   = neg_res ? -acc : acc;
        q_res     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_res     = neg_a ? -rem : rem;
        // sign-magnitude round trip recovers the original dividend, including the most negative value
        a_raw     = neg_a ? -a_mag : a_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            neg_a    <= 1'b0;
            neg_res  <= 1'b0;
            acc      <= '0;
            rem      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_mag   <= a_in;
                        b_mag   <= b_in;
                        neg_a   <= sgn_in & src_a[WIDTH-1];
                        neg_res <= sgn_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        acc     <= {{WIDTH{1'b0}}, (op[1] ? a_in : b_in)};
                        rem     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    if (op_q[1]) begin
                        if (take) begin
                            rem              <= shift_rem[WIDTH-1:0] - b_mag;
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem              <= shift_rem[WIDTH-1:0];
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {add_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (op_q[1]) begin
                        if (b_mag == '0) begin
                            hi       <= a_raw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi       <= r_res;
                            lo       <= q_res;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        {hi, lo} <= mul_res;
                        div_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit instance carries most scenarios, an 8-bit one covers
// parametrisation. Expected results are queued at launch and popped when done pulses.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wr_data, hi, lo;
    logic        busy, done, div_zero;

    logic        start8, wr_hi8, wr_lo8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wr_data8, hi8, lo8;
    logic        busy8, done8, div_zero8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(a), .src_b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .wr_hi(wr_hi8), .wr_lo(wr_lo8), .wr_data(wr_data8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(div_zero8)
    );

    // Reference behaviour built from native operators: {div_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] pa, pb;
        logic signed [31:0] sx, sy, q, r;
        logic [63:0] p;
        case (o)
            2'd0: begin
                pa = {{32{x[31]}}, x};
                pb = {{32{y[31]}}, y};
                p  = pa * pb;
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            2'd2: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                sx = x;
                sy = y;
                q  = sx / sy;
                r  = sx % sy;
                return {1'b0, r, q};
            end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez);
        exp_t e;
        int   n;
        sb.push_back('{hi: eh, lo: el, dz: ez});
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL done_latency: got edge E0+%0d want E0+33", n); end
        e = sb.pop_front();
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL hi op=%0d: got %h want %h", o, hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL lo op=%0d: got %h want %h", o, lo, e.lo); end
        checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL div_zero op=%0d: got %b want %b", o, div_zero, e.dz); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
    endtask

    task automatic run_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] eh, input logic [7:0] el);
        exp_t e;
        int   n;
        sb.push_back('{hi: {24'd0, eh}, lo: {24'd0, el}, dz: 1'b0});
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
            if (done8 === 1'b1) break;
        end
        checks++;
        if (n != 9) begin errors++; $display("FAIL w8_done_latency: got edge E0+%0d want E0+9", n); end
        e = sb.pop_front();
        checks++; if (hi8 !== e.hi[7:0]) begin errors++; $display("FAIL w8_hi op=%0d: got %h want %h", o, hi8, e.hi[7:0]); end
        checks++; if (lo8 !== e.lo[7:0]) begin errors++; $display("FAIL w8_lo op=%0d: got %h want %h", o, lo8, e.lo[7:0]); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL w8_done_one_cycle: got %b want 0", done8); end
    endtask

    task automatic test_reset;
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero}); end
        checks++; if ({hi8, lo8, busy8, done8} !== 18'd0) begin errors++; $display("FAIL reset_w8: got %h want 0", {hi8, lo8, busy8, done8}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", {busy, done}); end
    endtask

    task automatic test_signed;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    endtask

    task automatic test_unsigned;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(2'd3, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0);
    endtask

    task automatic test_boundary;
        run_op(2'd3, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    endtask

    task automatic test_random;
        logic [64:0] r;
        logic [31:0] x, y;
        logic [1:0]  o;
        for (int i = 0; i < 8; i++) begin
            o = 2'(i % 4);
            x = $urandom;
            y = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            r = model(o, x, y);
            run_op(o, x, y, r[63:32], r[31:0], r[64]);
        end
    endtask

    task automatic test_handshake;
        exp_t e;
        int   dones = 0;
        wr_lo = 1'b1; wr_data = 32'h1111;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        checks++; if (lo !== 32'h1111) begin errors++; $display("FAIL idle_wr_lo: got %h want 1111", lo); end
        sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        for (int k = 1; k <= 80; k++) begin
            start = (k == 5);
            if (k == 5) begin op = 2'd0; a = 32'd3; b = 32'd3; end
            wr_lo = (k == 8);
            wr_data = 32'hAA;
            @(posedge clk); #1;
            if (k == 8) begin
                checks++; if (lo !== 32'h1111) begin errors++; $display("FAIL busy_wr_lo: got %h want 1111", lo); end
            end
            if (done === 1'b1) begin
                dones++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL extra_done: unexpected done at E0+%0d", k);
                end else begin
                    e = sb.pop_front();
                    checks++; if (lo !== e.lo) begin errors++; $display("FAIL hs_lo: got %h want %h", lo, e.lo); end
                    checks++; if (hi !== e.hi) begin errors++; $display("FAIL hs_hi: got %h want %h", hi, e.hi); end
                end
            end
        end
        start = 1'b0; wr_lo = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL single_done: got %0d want 1", dones); end
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h55;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++; if (hi !== 32'h55) begin errors++; $display("FAIL idle_wr_hi: got %h want 55", hi); end
        checks++; if (lo !== 32'h55) begin errors++; $display("FAIL idle_wr_both_lo: got %h want 55", lo); end
    endtask

    task automatic test_reset_mid;
        start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL mid_reset_hilo: got %h want 0", {hi, lo}); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd1, 32'd131072, 32'd131072, 32'd4, 32'd0, 1'b0);
    endtask

    task automatic test_width8;
        run_op8(2'd0, 8'h80, 8'h80, 8'h40, 8'h00);
        run_op8(2'd2, 8'h81, 8'h03, 8'hFF, 8'hD6);
        run_op8(2'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; op = 2'd0; a = '0; b = '0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0; wr_hi8 = 1'b0; wr_lo8 = 1'b0; wr_data8 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_signed;
        test_unsigned;
        test_boundary;
        test_random;
        test_handshake;
        test_reset_mid;
        test_width8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
